// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   FETCH_DATA_W  : instruction/address width; it also sets the width of fetch_entry_t
//   PC_STEP_1/2   : byte offsets of the second slot and of a full dual fetch
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one queued instruction together with its PC
//   clamp_deq     : limits a decode pop request to the two read ports
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W = 32;
  localparam int unsigned PC_STEP_1    = 4;
  localparam int unsigned PC_STEP_2    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] inst;
    logic [FETCH_DATA_W-1:0] pc;
  } fetch_entry_t;

  // The queue has two read ports, so a request of 3 is served as 2.
  function automatic logic [1:0] clamp_deq(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/inst_queue_2w2r.sv
// Circular fetch queue. Each push writes two entries; each cycle pops 0..2 entries.
// The two oldest entries are read combinationally.
//   clk_i, rst_ni        : clock; asynchronous active-low reset of pointers and count
//   flush_i              : empties the queue. It overrides a push or pop in the same cycle.
//   push_i, push0/1_i    : writes two entries; push0_i is the older entry
//   pop_req_i            : requested pop count; the queue clamps it to 2 and to the occupancy
//   count_o              : current occupancy (registered)
//   head0/1_o, valid0/1_o: oldest two entries and their valid flags
//   over_o               : the pop request exceeded the occupancy this cycle
module inst_queue_2w2r
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push0_i,
  input  fetch_entry_t             push1_i,
  input  logic [1:0]               pop_req_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head0_o,
  output fetch_entry_t             head1_o,
  output logic                     valid0_o,
  output logic                     valid1_o,
  output logic                     over_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       req;
  logic [1:0]       pops;

  fetch_entry_t mem_q [DEPTH];

  assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  always_comb begin
    req    = clamp_deq(pop_req_i);
    over_o = CNT_W'(req) > count_q;
    // On an over-request the occupancy is at most 1, so it fits in the pop width.
    pops   = over_o ? count_q[1:0] : req;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pops);
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(2);
      end
      count_d = count_q + (push_i ? CNT_W'(2) : '0) - CNT_W'(pops);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reset does not clear the entries. The valid flags gate every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q]  <= push0_i;
      mem_q[wr_ptr_p1] <= push1_i;
    end
  end

  assign head0_o  = mem_q[rd_ptr_q];
  assign head1_o  = mem_q[rd_ptr_p1];
  assign valid0_o = count_q != '0;
  assign valid1_o = count_q >= CNT_W'(2);
  assign count_o  = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Dual-instruction fetch initiator. It requests instructions at pc and pc+4,
// buffers the returned pairs, and feeds decode up to two instructions per cycle.
// A redirect flushes the queue and restarts fetch.
//   clk, rst (async, active-low)
//   inst_address, InstMem_Read      : fetch request (slot 2 fetches inst_address+4)
//   InstMem_Ready, inst1_in/inst2_in: memory response, taken only while Read is high
//   redirect, redirect_pc           : flush and restart at redirect_pc with bits[1:0] cleared
//   deq_count                       : decode pops this many instructions (0..2; 3 acts as 2)
//   out_valid/inst/pc 1,2           : queue head and head+1
//   deq_err                         : sticky flag, set when decode pops more than is valid
// DATA_W must equal fetch_pkg::FETCH_DATA_W, because the queue entry record has that width.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        DATA_W   = FETCH_DATA_W,
  parameter int unsigned        DEPTH    = 8,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] inst_address,
  output logic              InstMem_Read,
  input  logic              InstMem_Ready,
  input  logic [DATA_W-1:0] inst1_in,
  input  logic [DATA_W-1:0] inst2_in,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic [1:0]        deq_count,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic [DATA_W-1:0] out_inst1,
  output logic [DATA_W-1:0] out_inst2,
  output logic [DATA_W-1:0] out_pc1,
  output logic [DATA_W-1:0] out_pc2,
  output logic              deq_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              deq_err_q, deq_err_d;

  logic [CNT_W-1:0]  q_count;
  logic              q_over;
  logic              has_room;
  logic              accept;
  fetch_entry_t      push0, push1, head0, head1;

  // Read depends only on the registered count. A pop in the same cycle cannot
  // raise Read early, so a simultaneous push and pop cannot overflow the queue.
  assign has_room     = (CNT_W'(DEPTH) - q_count) >= CNT_W'(2);
  assign InstMem_Read = (state_q == ST_FETCH) && has_room && !redirect;
  assign accept       = InstMem_Read && InstMem_Ready;
  assign inst_address = pc_q;

  always_comb begin
    push0      = '0;
    push1      = '0;
    push0.inst = inst1_in;
    push0.pc   = pc_q;
    push1.inst = inst2_in;
    push1.pc   = pc_q + DATA_W'(PC_STEP_1);
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    deq_err_d = deq_err_q;
    if (redirect) begin
      state_d = ST_FLUSH;
      pc_d    = {redirect_pc[DATA_W-1:2], 2'b00};
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: state_d = ST_FETCH;
        ST_FLUSH: state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
      if (accept) begin
        pc_d = pc_q + DATA_W'(PC_STEP_2);
      end
      // A redirect discards the pops of its cycle, so an over-request in that cycle is not flagged.
      deq_err_d = deq_err_q | q_over;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      deq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      deq_err_q <= deq_err_d;
    end
  end

  inst_queue_2w2r #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (redirect),
    .push_i   (accept),
    .push0_i  (push0),
    .push1_i  (push1),
    .pop_req_i(deq_count),
    .count_o  (q_count),
    .head0_o  (head0),
    .head1_o  (head1),
    .valid0_o (out_valid1),
    .valid1_o (out_valid2),
    .over_o   (q_over)
  );

  assign out_inst1 = head0.inst;
  assign out_inst2 = head1.inst;
  assign out_pc1   = head0.pc;
  assign out_pc2   = head1.pc;
  assign deq_err   = deq_err_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Processor-side initiator of the dual-instruction memory fetch interface. It drives InstMem_Read and inst_address, and accepts two instructions per handshake (addr and addr+4) when InstMem_Ready is high. Accepted instructions are buffered in a circular fetch queue that feeds decode at up to two instructions per cycle. Branch and exception redirects flush the queue and restart fetch.

Parameters:
DATA_W, 32, instruction/address width
DEPTH, 8, fetch queue entries; power of two, >= 4
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
inst_address  out  DATA_W  fetch address for slot 1; slot 2 is inst_address+4
InstMem_Read  out  1  fetch request
InstMem_Ready  in  1  memory returns inst1_in/inst2_in this cycle
inst1_in  in  DATA_W  instruction at inst_address
inst2_in  in  DATA_W  instruction at inst_address+4
redirect  in  1  flush and restart fetch
redirect_pc  in  DATA_W  new fetch PC; bits[1:0] forced to 0
deq_count  in  2  instructions decode consumes this cycle (0..2)
out_valid1/out_valid2  out  1  queue head / head+1 valid
out_inst1/out_inst2  out  DATA_W  head / head+1 instruction
out_pc1/out_pc2  out  DATA_W  PC of each
deq_err  out  1  registered, sticky: deq_count exceeded valid entries

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; queue pointers and count=0; state=IDLE.
  - All out_valid=0, InstMem_Read=0, deq_err=0. Queue data is not cleared.
- FSM states: IDLE, FETCH, FLUSH.
  - IDLE -> FETCH on the first edge after reset release.
  - FETCH -> FLUSH on redirect.
  - FLUSH -> FETCH after one cycle, unless redirect is high again (update pc, stay in FLUSH).
- InstMem_Read = (state==FETCH) && (DEPTH-count >= 2) && !redirect.
  - Decided on registered count only; no combinational path from deq_count to Read.
- inst_address = pc. It holds stable while Read is high and Ready is low. Only redirect may change it mid-request.
- Handshake: accepted at a rising edge where Read && Ready.
  - Push {inst1_in, pc} and {inst2_in, pc+4}.
  - pc <= pc+8 (wraps modulo 2^DATA_W).
  - Ready while Read=0 is ignored.
- Latency: an instruction accepted at edge N appears on out_* immediately after edge N. Queue-to-decode latency is 0 extra cycles.
- Dequeue at edge: pop min(deq_count, valid entries).
  - deq_count=3 is treated as 2.
  - Over-request sets deq_err; no underflow, count never negative.
- Simultaneous push+pop: count_next = count + 2·accept − pops. Read gating guarantees this never exceeds DEPTH.
- Pointers are log2(DEPTH) bits with natural wrap. out_*2 reads rd_ptr+1 modulo DEPTH.
- out_valid1 = count>=1; out_valid2 = count>=2.
- Redirect (any state) at edge:
  - count=0, rd_ptr=wr_ptr=0, pc=redirect_pc&~3.
  - Same-cycle Ready data and same-cycle pops are discarded.
  - Read is low during the redirect cycle and the FLUSH cycle, then resumes from the new pc.
- Reset mid-request: Read drops asynchronously. The memory responder must tolerate an abandoned request.

Decomposition:
- Shared package fetch_pkg:
  - DATA_W default
  - state encoding (IDLE/FETCH/FLUSH)
  - entry record (inst, pc)
  - PC increment constants 4 and 8
- Sub-module inst_queue_2w2r: circular buffer with 2-wide push, 0–2 pop, flush, count, and underflow clamp.
- inst_fetch_unit holds the FSM, pc, and handshake logic.

Test Plan:
1. Memory model returns mem[a>>2], mem[(a>>2)+1] combinationally with Ready=Read; deq_count=2 every cycle -> addresses 0x0, 0x8, 0x10…; every cycle out_pc1=N·8, out_pc2=N·8+4 with matching instructions, no gaps after the first.
2. deq_count=0, Ready=Read, DEPTH=8 -> four handshakes (0x0..0x18). Read falls with count=8; inst_address holds 0x20. deq_count=2 for one cycle -> count=6, Read rises the next cycle.
3. Ready held low 3 cycles after Read rises -> inst_address=0x0 stable, count stays 0. On Ready, count=2, out_pc1=0x0, out_pc2=0x4.
4. redirect=1, redirect_pc=0x107, Ready=1 and deq_count=2 in the same cycle with count=4 -> next cycle count=0, out_valid1=0, Read=0 for 2 cycles. Then inst_address=0x104; after accept, out_pc1=0x104, out_pc2=0x108.
5. rst pulled low mid-cycle with count=5 -> out_valid1/2 and Read go 0 before the next edge. After release: one IDLE cycle, then inst_address=RESET_PC.
6. count=1, deq_count=2 -> one pop, count=0, deq_err=1 and stays 1 until reset; later fetches unaffected. deq_count=3 with count=4 -> pops 2.
